// File: rtl/ab_cd_seq_checker.sv
// Checks the a -> b -> c -> (gap) -> d sequence on single-bit inputs; counts passes and failures.
// Optional sticky error flag enabled by defining AB_CD_SEQ_CHECKER_STICKY_ERR_EN.
module ab_cd_seq_checker #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       fail_stage,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
`ifdef AB_CD_SEQ_CHECKER_STICKY_ERR_EN
    ,
    input  logic             clr_err,
    output logic             err_sticky
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHK_B = 3'd1,
        CHK_C = 3'd2,
        GAP   = 3'd3,
        CHK_D = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t     state;
    logic       pass_hit;
    logic       fail_hit;
    logic [1:0] hit_stage;

    // Decision decode; an if() on an X/Z input takes the else branch, so unknowns read as 0.
    always_comb begin
        pass_hit  = 1'b0;
        fail_hit  = 1'b0;
        hit_stage = 2'd0;
        if (en) begin
            case (state)
                CHK_B: begin
                    if (b) fail_hit = 1'b0;
                    else begin
                        fail_hit  = 1'b1;
                        hit_stage = 2'd1;
                    end
                end
                CHK_C: begin
                    if (c) fail_hit = 1'b0;
                    else begin
                        fail_hit  = 1'b1;
                        hit_stage = 2'd2;
                    end
                end
                CHK_D: begin
                    if (d) pass_hit = 1'b1;
                    else begin
                        fail_hit  = 1'b1;
                        hit_stage = 2'd3;
                    end
                end
                default: begin
                    pass_hit  = 1'b0;
                    fail_hit  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pass       <= 1'b0;
            fail       <= 1'b0;
            fail_stage <= 2'd0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
        end else begin
            pass <= pass_hit;
            fail <= fail_hit;
            if (fail_hit) begin
                fail_stage <= hit_stage;
                if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_ONE;
            end
            if (pass_hit && (pass_cnt != CNT_MAX)) pass_cnt <= pass_cnt + CNT_ONE;

            if (en) begin
                case (state)
                    IDLE:    if (a) state <= CHK_B;
                    CHK_B:   state <= b ? CHK_C : IDLE;
                    CHK_C:   state <= c ? GAP : IDLE;
                    GAP:     state <= CHK_D;
                    CHK_D:   state <= IDLE;
                    default: state <= IDLE;
                endcase
            end else begin
                // Silent abort: no decision is decoded while en is low.
                state <= IDLE;
            end
        end
    end

    assign busy = (state != IDLE);

`ifdef AB_CD_SEQ_CHECKER_STICKY_ERR_EN
    // A new failure on the same edge as a clear leaves the flag set.
    always_ff @(posedge clk) begin
        if (rst)           err_sticky <= 1'b0;
        else if (fail_hit) err_sticky <= 1'b1;
        else if (clr_err)  err_sticky <= 1'b0;
    end
`endif

endmodule

// File: doc/ab_cd_seq_checker.md
AB_CD_SEQ_CHECKER -- requirements
Module: ab_cd_seq_checker

Interface
REQ-001 Parameter CNT_W, default 16: width of the pass and fail counters; legal range 4..32.
REQ-002 Port clk, input, 1: the single clock; all state is updated on its rising edge.
REQ-003 Port rst, input, 1: synchronous, active-high reset.
REQ-004 Port en, input, 1: checker enable.
REQ-005 Ports a, b, c, d, input, 1 each: monitored signals from the upstream stimulus stage, sampled on the rising edge of clk.
REQ-006 Port busy, output, 1: high while an attempt is in progress (state other than IDLE).
REQ-007 Port pass, output, 1: one-cycle pulse when an attempt completes successfully.
REQ-008 Port fail, output, 1: one-cycle pulse when an attempt fails.
REQ-009 Port fail_stage, output, 2: step at which the last failure occurred (1=b, 2=c, 3=d); held until the next failure.
REQ-010 Port pass_cnt, output, CNT_W: saturating count of passes.
REQ-011 Port fail_cnt, output, CNT_W: saturating count of failures.

Function
REQ-012 Checked sequence, with edge T as the start: a=1 at T, b=1 at T+1, c=1 at T+2, d=1 at T+4; d is not examined at T+3.
REQ-013 State machine states: IDLE, CHK_B, CHK_C, GAP, CHK_D.
REQ-014 IDLE: if en=1 and a=1, go to CHK_B; otherwise stay in IDLE.
REQ-015 CHK_B: if b=1, go to CHK_C; if b=0, fail with stage 1 and go to IDLE.
REQ-016 CHK_C: if c=1, go to GAP; if c=0, fail with stage 2 and go to IDLE.
REQ-017 GAP: go to CHK_D unconditionally.
REQ-018 CHK_D: if d=1, pass; if d=0, fail with stage 3; go to IDLE in either case.
REQ-019 Attempts do not overlap: a is sampled only in IDLE, and a start is never accepted on the same edge as a pass or fail decision.
REQ-020 pass and fail are registered; each is high for exactly the one cycle following its deciding edge.
REQ-021 pass and fail are never high in the same cycle.
REQ-022 Each counter increments by 1 on the edge that registers its pulse.
REQ-023 Each counter holds at 2^CNT_W-1 once reached; it does not wrap.
REQ-024 If en=0 in any non-IDLE state, the attempt is aborted silently: go to IDLE, no pass or fail pulse, counters unchanged.
REQ-025 Counters and fail_stage hold their values while en=0.
REQ-026 Inputs that are X or Z are treated as 0 by the decision logic; the bench drives only 0 or 1.

Reset
REQ-027 While rst=1 on an edge, the following are set:
- state = IDLE;
- busy = 0, pass = 0, fail = 0;
- fail_stage = 0;
- pass_cnt = 0, fail_cnt = 0.
REQ-028 rst=1 mid-attempt abandons the attempt without a pass or fail pulse.
REQ-029 rst has priority over en and over all other inputs.
REQ-030 The first start can be accepted on the first edge where rst=0.

Configuration
REQ-031 Macro AB_CD_SEQ_CHECKER_STICKY_ERR_EN, when defined, adds two ports:
- input clr_err, 1 bit;
- output err_sticky, 1 bit.
REQ-032 err_sticky is set in the same cycle as the first fail pulse and stays high until clr_err=1 or rst=1.
REQ-033 When clr_err=1 and a new fail are registered on the same edge, err_sticky ends high (set wins).
REQ-034 When AB_CD_SEQ_CHECKER_STICKY_ERR_EN is undefined, neither port exists and all other behaviour is identical.

Verification
REQ-035 Pass case: a=1 at T, b=1 at T+1, c=1 at T+2, d=0 at T+3, d=1 at T+4 -> pass=1 in the cycle after T+4, pass_cnt=1, fail_cnt=0.
REQ-036 Fail at b: a=1 at T, b=0 at T+1 -> fail=1 in the cycle after T+1, fail_stage=1, fail_cnt=1, busy=0 from then on.
REQ-037 Fail at d and no overlap: a held at 1 throughout, b=1, c=1, d=0 at T+4 -> exactly one fail with fail_stage=3; the next attempt starts at T+5, not at T+1.
REQ-038 Abort and reset: en dropped to 0 at T+2 -> no pulse, counters unchanged; separately, rst=1 at T+3 -> all outputs 0 on the next cycle.
REQ-039 Saturation: with CNT_W=4, run 20 passing attempts -> pass_cnt stops and holds at 15.
REQ-040 Sticky error (macro defined): one failure -> err_sticky=1; clr_err=1 -> err_sticky=0; clr_err=1 on the same edge as a new fail -> err_sticky=1.
